// File: rtl/systolic_mac_pe.sv
// ============================================================================
// Module   : systolic_mac_pe
// Brief    : Systolic-array MAC processing element with east/south operand
//            forwarding, K-term dot-product accumulation and sticky error flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_mac_pe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic             b_in_valid,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_out_valid,
    output logic [WIDTH-1:0] a_out,
    output logic             b_out_valid,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err
);

    localparam int unsigned   C_CNT_W = $clog2(K) + 1;
    localparam [C_CNT_W-1:0]  C_LAST  = C_CNT_W'(K - 1);

    logic               r_a_valid;
    logic [WIDTH-1:0]   r_a;
    logic               r_b_valid;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_valid;
    logic               r_err;

    logic               w_pair;
    logic               w_misalign;
    logic               w_last;
    logic [WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]   w_sum;

    assign w_pair     = a_in_valid & b_in_valid;
    assign w_misalign = a_in_valid ^ b_in_valid;
    assign w_last     = (r_cnt == C_LAST);
    // Product and sum both deliberately truncate to WIDTH bits (mod 2^WIDTH).
    assign w_prod     = a_in * b_in;
    assign w_sum      = r_acc + w_prod;

    // Operand forwarding supplies the array skew; data moves even when invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid <= 1'b0;
            r_a       <= '0;
            r_b_valid <= 1'b0;
            r_b       <= '0;
        end else begin
            r_a_valid <= a_in_valid;
            r_a       <= a_in;
            r_b_valid <= b_in_valid;
            r_b       <= b_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_pair & w_last;
            if (w_pair) begin
                if (w_last) begin
                    r_result <= w_sum;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc    <= w_sum;
                    r_cnt    <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky until reset; a lone operand never touches acc/cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_misalign) begin
            r_err <= 1'b1;
        end
    end

    assign a_out_valid  = r_a_valid;
    assign a_out        = r_a;
    assign b_out_valid  = r_b_valid;
    assign b_out        = r_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_systolic_mac_pe.sv
// ============================================================================
// Module   : tb_systolic_mac_pe
// Brief    : Scoreboard bench for systolic_mac_pe with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_mac_pe;

    logic        clk;
    logic        rst;
    logic        a_in_valid;
    logic [31:0] a_in;
    logic        b_in_valid;
    logic [31:0] b_in;
    logic        a_out_valid;
    logic [31:0] a_out;
    logic        b_out_valid;
    logic [31:0] b_out;
    logic [31:0] result;
    logic        result_valid;
    logic        err;

    systolic_mac_pe #(.WIDTH(32), .K(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .a_in_valid   (a_in_valid),
        .a_in         (a_in),
        .b_in_valid   (b_in_valid),
        .b_in         (b_in),
        .a_out_valid  (a_out_valid),
        .a_out        (a_out),
        .b_out_valid  (b_out_valid),
        .b_out        (b_out),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          strobe_t[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic        cap_av, cap_bv, exp_err;
    logic [31:0] cap_a, cap_b, exp_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference for pass-through and sticky error, updated on the sampling edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_av  = 1'b0;
            cap_a   = '0;
            cap_bv  = 1'b0;
            cap_b   = '0;
            exp_err = 1'b0;
        end else begin
            cap_av = a_in_valid;
            cap_a  = a_in;
            cap_bv = b_in_valid;
            cap_b  = b_in;
            if (a_in_valid ^ b_in_valid) exp_err = 1'b1;
        end
        if (clk) cyc++;
    end

    // Monitor: samples on the falling edge and pops the scoreboard on strobes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) exp_hold = '0;
        check("a_out_valid", {31'd0, a_out_valid}, {31'd0, cap_av});
        check("a_out",       a_out,                cap_a);
        check("b_out_valid", {31'd0, b_out_valid}, {31'd0, cap_bv});
        check("b_out",       b_out,                cap_b);
        check("err",         {31'd0, err},         {31'd0, exp_err});
        if (result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result",       result,      e.v);
                check("result_cycle", 32'(cyc),    32'(e.t));
                exp_hold = e.v;
                strobe_t.push_back(cyc);
            end
        end else begin
            check("result_hold", result, exp_hold);
        end
    end

    // Drives one cycle of inputs; optionally registers the completion it causes.
    task automatic drive(input bit av, input logic [31:0] a, input bit bv, input logic [31:0] b,
                         input bit push = 1'b0, input logic [31:0] ev = '0);
        exp_t e;
        @(posedge clk);
        #1;
        a_in_valid = av;
        a_in       = a;
        b_in_valid = bv;
        b_in       = b;
        if (push) begin
            e.v = ev;
            e.t = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0, $urandom);
    endtask

    initial begin
        rst        = 1'b0;
        a_in_valid = 1'b0;
        a_in       = '0;
        b_in_valid = 1'b0;
        b_in       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic dot product
        drive(1, 1, 1, 5);
        drive(1, 2, 1, 6);
        drive(1, 3, 1, 7);
        drive(1, 4, 1, 8, 1, 70);
        idle(3);

        // Back-to-back, strobes 4 cycles apart
        strobe_t.delete();
        drive(1, 1, 1, 5);
        drive(1, 2, 1, 6);
        drive(1, 3, 1, 7);
        drive(1, 4, 1, 8, 1, 70);
        drive(1, 2, 1, 3);
        drive(1, 2, 1, 3);
        drive(1, 2, 1, 3);
        drive(1, 2, 1, 3, 1, 24);
        idle(3);
        if (strobe_t.size() == 2) check("strobe_spacing", 32'(strobe_t[1] - strobe_t[0]), 32'd4);
        else                      check("strobe_count", 32'(strobe_t.size()), 32'd2);

        // Gaps with random data on idle cycles
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'(i), 1, 1, i == 4, 10);
            if (i < 4) idle(2);
        end
        idle(2);

        // Wrap-around
        for (int i = 0; i < 4; i++) drive(1, 32'h0001_0000, 1, 32'h0001_0000, i == 3, 0);
        for (int i = 0; i < 4; i++) drive(1, 32'hFFFF_FFFF, 1, 1, i == 3, 32'hFFFF_FFFC);
        idle(2);

        // Reset in the middle of a dot product
        drive(1, 9, 1, 9);
        drive(1, 9, 1, 9);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, i == 3, 4);
        idle(2);

        // Lone A operand among proper pairs
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 1);
        drive(1, 100, 0, 0);
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 1, 1, 4);
        idle(3);
        check("err_sticky", {31'd0, err}, 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
